// File: rtl/fetch_unit_pkg.sv
// Shared fetch pipeline types and constants: queue entry layout, reset vector
// and the canonical NOP encoding.
package fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with combinational head read and a synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// matching against captured PCs, and redirect handling that discards stale fetches.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic [31:0] out_inst
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] QDEPTH_S = SW'(QDEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          started_q, started_d;

    logic [CW-1:0] q_count;
    logic [CW-1:0] aq_count;
    logic [SW-1:0] credit_sum;
    fetch_entry_t  q_head;
    fetch_entry_t  q_push_data;
    logic [31:0]   aq_head;

    logic req_xfer;
    logic rv_drop;
    logic rv_live;
    logic out_fire;
    logic q_empty;
    logic fifo_flush;
    logic aq_push;
    logic q_push;

    // The address FIFO holds exactly the live (non-dropped) outstanding requests,
    // so its occupancy doubles as the in-flight count.
    always_comb begin
        credit_sum  = SW'(q_count) + SW'(aq_count) + SW'(drop_q);
        imem_req    = reset && started_q && !redirect_valid && (credit_sum < QDEPTH_S);
        imem_addr   = fetch_pc_q;
        req_xfer    = imem_req && imem_ready;
        rv_drop     = imem_rvalid && (drop_q != '0);
        rv_live     = imem_rvalid && (drop_q == '0) && (aq_count != '0);
        q_empty     = (q_count == '0);
        out_valid   = !q_empty && !redirect_valid;
        out_fire    = out_valid && out_ready;
        fifo_flush  = redirect_valid || !reset;
        aq_push     = req_xfer && !redirect_valid;
        q_push      = rv_live && !redirect_valid;
        q_push_data.pc   = aq_head;
        q_push_data.inst = imem_rdata;
        out_pc      = q_empty ? 32'h0 : q_head.pc;
        out_pcplus4 = q_empty ? 32'h0 : q_head.pc + 32'd4;
        out_inst    = q_empty ? 32'h0 : q_head.inst;
    end

    // On redirect every live outstanding request turns into a pending drop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q - CW'(rv_drop);
        started_d  = 1'b1;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            drop_d     = drop_q - CW'(rv_drop) + aq_count + CW'(req_xfer) - CW'(rv_live);
        end else if (req_xfer) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            started_q  <= started_d;
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (QDEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (aq_push),
        .push_data (fetch_pc_q),
        .pop       (rv_live),
        .head_data (aq_head),
        .count     (aq_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (out_fire),
        .head_data (q_head),
        .count     (q_count)
    );

endmodule
